// File: rtl/mux_channel_scanner.sv
// Round-robin select sequencer for a channel mux: dwells on each enabled channel,
// then captures the mux output onto a valid/ready port without ever dropping a sample.
module mux_channel_scanner #(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DWELL  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_ch,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int unsigned      CNT_W    = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {
    S_IDLE,
    S_DWELL
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic [SEL_W-1:0]    first_sel;
  logic                first_found;
  logic [SEL_W-1:0]    next_sel;
  logic                next_found;
  int unsigned         idx;

  // Lowest enabled channel, used when leaving IDLE.
  always_comb begin
    first_sel   = '0;
    first_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!first_found && 1'(ch_mask >> i)) begin
        first_sel   = SEL_W'(i);
        first_found = 1'b1;
      end
    end
  end

  // Search starts one past the current channel and wraps back onto it, so a
  // mask holding only the current channel keeps sel where it is.
  always_comb begin
    next_sel   = sel_q;
    next_found = 1'b0;
    idx        = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = (32'(sel_q) + i) % NUM_CH;
      if (!next_found && 1'(ch_mask >> idx)) begin
        next_sel   = SEL_W'(idx);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (run && first_found) begin
          sel_d   = first_sel;
          cnt_d   = '0;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (!run) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!out_valid_q || out_ready) begin
          // Capture overrides the accept-clear above: a new sample replaces the old.
          out_data_d  = mux_data;
          out_ch_d    = sel_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          if (next_found) begin
            sel_d = next_sel;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == S_DWELL);

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner with a 2*sel mux model and
// hand-computed channel/data sequences.
module tb_mux_channel_scanner;

  logic       clk;
  logic       reset;
  logic       run;
  logic [5:0] ch_mask;
  logic [2:0] sel;
  logic [3:0] mux_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_ch;
  logic [3:0] out_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  mux_channel_scanner #(
    .NUM_CH (6),
    .SEL_W  (3),
    .DATA_W (4),
    .DWELL  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .ch_mask   (ch_mask),
    .sel       (sel),
    .mux_data  (mux_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .busy      (busy)
  );

  assign mux_data = 4'(sel) << 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    run       = 1'b0;
    ch_mask   = '0;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Three dwell cycles with nothing valid, then a capture on the fourth edge.
  task automatic dwell_capture(input int ech, input int edat, input int esel);
    repeat (3) step();
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_busy", 32'(busy), 1);
    step();
    chk("cap_valid", 32'(out_valid), 1);
    chk("cap_ch", 32'(out_ch), ech);
    chk("cap_data", 32'(out_data), edat);
    chk("cap_sel", 32'(sel), esel);
  endtask

  int t1_ch  [7] = '{0, 1, 2, 3, 4, 5, 0};
  int t1_dat [7] = '{0, 2, 4, 6, 8, 10, 0};
  int t1_sel [7] = '{1, 2, 3, 4, 5, 0, 1};

  initial begin
    reset = 1'b1; run = 1'b0; ch_mask = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // Full scan
    run = 1'b1; ch_mask = 6'b111111; out_ready = 1'b1;
    step();
    chk("t1_start_busy", 32'(busy), 1);
    chk("t1_start_sel", 32'(sel), 0);
    for (int k = 0; k < 7; k++) dwell_capture(t1_ch[k], t1_dat[k], t1_sel[k]);

    // Sparse mask, then a single-channel mask applied mid-dwell
    do_reset();
    run = 1'b1; ch_mask = 6'b100100; out_ready = 1'b1;
    step();
    chk("t2_start_sel", 32'(sel), 2);
    dwell_capture(2, 4, 5);
    dwell_capture(5, 10, 2);
    dwell_capture(2, 4, 5);
    dwell_capture(5, 10, 2);
    ch_mask = 6'b000100;
    dwell_capture(2, 4, 2);
    dwell_capture(2, 4, 2);
    dwell_capture(2, 4, 2);

    // Backpressure
    do_reset();
    run = 1'b1; ch_mask = 6'b111111; out_ready = 1'b0;
    step();
    repeat (4) step();
    chk("t3_cap_valid", 32'(out_valid), 1);
    chk("t3_cap_ch", 32'(out_ch), 0);
    repeat (12) step();
    chk("t3_hold_valid", 32'(out_valid), 1);
    chk("t3_hold_ch", 32'(out_ch), 0);
    chk("t3_hold_data", 32'(out_data), 0);
    chk("t3_hold_sel", 32'(sel), 1);
    chk("t3_hold_cnt", 32'(dut.cnt_q), 3);
    chk("t3_hold_busy", 32'(busy), 1);
    out_ready = 1'b1;
    step();
    chk("t3_swap_valid", 32'(out_valid), 1);
    chk("t3_swap_ch", 32'(out_ch), 1);
    chk("t3_swap_data", 32'(out_data), 2);
    chk("t3_swap_sel", 32'(sel), 2);

    // Empty mask
    do_reset();
    run = 1'b1; ch_mask = 6'b000000; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t4_idle_busy", 32'(busy), 0);
      chk("t4_idle_sel", 32'(sel), 0);
      chk("t4_idle_valid", 32'(out_valid), 0);
    end
    ch_mask = 6'b001000;
    step();
    chk("t4_start_sel", 32'(sel), 3);
    repeat (3) step();
    ch_mask = 6'b000000;
    step();
    chk("t4_cap_valid", 32'(out_valid), 1);
    chk("t4_cap_ch", 32'(out_ch), 3);
    chk("t4_cap_data", 32'(out_data), 6);
    chk("t4_cap_busy", 32'(busy), 0);
    chk("t4_cap_sel", 32'(sel), 3);
    step();
    chk("t4_after_valid", 32'(out_valid), 0);
    chk("t4_after_busy", 32'(busy), 0);

    // Reset mid-dwell with a pending sample
    do_reset();
    run = 1'b1; ch_mask = 6'b111110; out_ready = 1'b0;
    step();
    repeat (4) step();
    chk("t5_cap_ch", 32'(out_ch), 1);
    chk("t5_cap_data", 32'(out_data), 2);
    repeat (2) step();
    chk("t5_cnt", 32'(dut.cnt_q), 2);
    chk("t5_pending", 32'(out_valid), 1);
    reset = 1'b1;
    step();
    chk("t5_sel", 32'(sel), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_ch", 32'(out_ch), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_busy", 32'(busy), 0);
    reset = 1'b0;

    // run dropped mid-dwell with an unaccepted sample
    do_reset();
    run = 1'b1; ch_mask = 6'b111110; out_ready = 1'b0;
    step();
    repeat (4) step();
    step();
    chk("t6_cnt", 32'(dut.cnt_q), 1);
    run = 1'b0;
    step();
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_keep_valid", 32'(out_valid), 1);
    chk("t6_keep_ch", 32'(out_ch), 1);
    chk("t6_keep_data", 32'(out_data), 2);
    chk("t6_keep_sel", 32'(sel), 2);
    step();
    chk("t6_keep2_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    step();
    chk("t6_accept_valid", 32'(out_valid), 0);
    run = 1'b1;
    step();
    chk("t6_restart_busy", 32'(busy), 1);
    chk("t6_restart_sel", 32'(sel), 1);
    dwell_capture(1, 2, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
